dcpu16_alux: RTL

- Parametrised, multi-cycle successor to the DCPU16 execute-stage ALU.
- Covers the full basic opcode set, including the ops the single-cycle ALU leaves unimplemented:
  - DIV and MOD, by iterative restoring division;
  - SHL and SHR, with overflow (O) capture.
- Data width W is generic.
- Sits between the operand fetch logic (regA/regB) and writeback. Writeback reads res and ovf.
- Accepts one operation at a time through a start/busy/done handshake.

---
 rtl/dcpu16_alux.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/dcpu16_alux.sv
`default_nettype none
// ============================================================================
// Module      : dcpu16_alux
// Description : Multi-cycle DCPU16 execute-stage ALU. Covers the whole basic
//               opcode set. DIV and MOD use an iterative restoring divider,
//               and SHL/SHR capture the bits shifted out in the O register.
//               A start/busy/done handshake accepts one operation at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module dcpu16_alux #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         start,
  input  logic [3:0]   opc,
  input  logic [W-1:0] src,
  input  logic [W-1:0] tgt,
  output logic [W-1:0] res,
  output logic [W-1:0] ovf,
  output logic         cc,
  output logic         busy,
  output logic         done
);

  // Basic opcode encodings
  localparam logic [3:0] c_OP_JSR = 4'h0;
  localparam logic [3:0] c_OP_SET = 4'h1;
  localparam logic [3:0] c_OP_ADD = 4'h2;
  localparam logic [3:0] c_OP_SUB = 4'h3;
  localparam logic [3:0] c_OP_MUL = 4'h4;
  localparam logic [3:0] c_OP_DIV = 4'h5;
  localparam logic [3:0] c_OP_MOD = 4'h6;
  localparam logic [3:0] c_OP_SHL = 4'h7;
  localparam logic [3:0] c_OP_SHR = 4'h8;
  localparam logic [3:0] c_OP_AND = 4'h9;
  localparam logic [3:0] c_OP_BOR = 4'hA;
  localparam logic [3:0] c_OP_XOR = 4'hB;
  localparam logic [3:0] c_OP_IFE = 4'hC;
  localparam logic [3:0] c_OP_IFN = 4'hD;
  localparam logic [3:0] c_OP_IFG = 4'hE;
  localparam logic [3:0] c_OP_IFB = 4'hF;

  // Iteration counter is wide enough to hold 2W-1, the last DIV iteration index
  localparam int CW = $clog2(2 * W) + 1;
  localparam logic [CW-1:0] c_DIV_LAST = CW'(2 * W - 1);
  localparam logic [CW-1:0] c_MOD_LAST = CW'(W - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_DIVIDE = 1'b1
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_res;
  logic [W-1:0]     r_ovf;
  logic             r_cc;
  logic             r_busy;
  logic             r_done;
  logic [W:0]       r_rem;     // partial remainder
  logic [2*W-1:0]   r_quo;     // dividend shifts out the top, quotient in the bottom
  logic [W-1:0]     r_dsr;     // latched divisor
  logic             r_is_mod;
  logic [CW-1:0]    r_cnt;

  // Single-cycle datapath
  logic [W:0]       w_add;
  logic [2*W-1:0]   w_mul;
  logic [2*W-1:0]   w_shl;
  logic [2*W-1:0]   w_shr;
  logic [W-1:0]     w_sc_res;
  logic [W-1:0]     w_sc_ovf;
  logic             w_sc_cc;
  logic             w_tgt_zero;
  logic             w_go_divide;

  // Divider step
  logic [W+1:0]     w_shift;
  logic [W+1:0]     w_diff;
  logic             w_fits;
  logic [W:0]       w_rem_nx;
  logic [2*W-1:0]   w_quo_nx;
  logic [CW-1:0]    w_last;

  assign w_add = {1'b0, src} + {1'b0, tgt};
  assign w_mul = {{W{1'b0}}, src} * {{W{1'b0}}, tgt};
  // Shifting a 2W-bit vector by tgt >= 2W yields zero, which covers the
  // large-shift case with no extra logic.
  assign w_shl = {{W{1'b0}}, src} << tgt;
  assign w_shr = {src, {W{1'b0}}} >> tgt;

  assign w_tgt_zero  = (tgt == '0);
  assign w_go_divide = ((opc == c_OP_DIV) || (opc == c_OP_MOD)) && !w_tgt_zero;

  // Restoring step: bring the next dividend bit into the remainder and keep
  // the trial difference only when it does not borrow. The remainder is always
  // below the divisor, so the extra top bit of the difference is a clean borrow.
  assign w_shift  = {r_rem, r_quo[2*W-1]};
  assign w_diff   = w_shift - {2'b00, r_dsr};
  assign w_fits   = ~w_diff[W+1];
  assign w_rem_nx = w_fits ? w_diff[W:0] : w_shift[W:0];
  assign w_quo_nx = {r_quo[2*W-2:0], w_fits};
  assign w_last   = r_is_mod ? c_MOD_LAST : c_DIV_LAST;

  // Results of all operations that complete on the accepting edge
  always_comb begin
    w_sc_res = r_res;
    w_sc_ovf = r_ovf;
    w_sc_cc  = 1'b1;
    case (opc)
      c_OP_JSR: w_sc_res = src;
      c_OP_SET: w_sc_res = tgt;
      c_OP_ADD: begin
        w_sc_res = w_add[W-1:0];
        w_sc_ovf = {{(W-1){1'b0}}, w_add[W]};
      end
      c_OP_SUB: begin
        w_sc_res = src - tgt;
        w_sc_ovf = (src < tgt) ? {W{1'b1}} : {W{1'b0}};
      end
      c_OP_MUL: begin
        w_sc_res = w_mul[W-1:0];
        w_sc_ovf = w_mul[2*W-1:W];
      end
      // Only reaches here as division by zero; non-zero divisors iterate
      c_OP_DIV: begin
        w_sc_res = '0;
        w_sc_ovf = '0;
      end
      c_OP_MOD: w_sc_res = '0;
      c_OP_SHL: begin
        w_sc_res = w_shl[W-1:0];
        w_sc_ovf = w_shl[2*W-1:W];
      end
      c_OP_SHR: begin
        w_sc_res = w_shr[2*W-1:W];
        w_sc_ovf = w_shr[W-1:0];
      end
      c_OP_AND: w_sc_res = src & tgt;
      c_OP_BOR: w_sc_res = src | tgt;
      c_OP_XOR: w_sc_res = src ^ tgt;
      c_OP_IFE: w_sc_cc = (src == tgt);
      c_OP_IFN: w_sc_cc = (src != tgt);
      c_OP_IFG: w_sc_cc = (src > tgt);
      c_OP_IFB: w_sc_cc = ((src & tgt) != '0);
      default: begin
        w_sc_res = r_res;
        w_sc_ovf = r_ovf;
        w_sc_cc  = 1'b1;
      end
    endcase
  end

  // Handshake FSM, divider iteration and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_res    <= '0;
      r_ovf    <= '0;
      r_cc     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dsr    <= '0;
      r_is_mod <= 1'b0;
      r_cnt    <= '0;
    end else if (ena) begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_go_divide) begin
              r_state  <= S_DIVIDE;
              r_busy   <= 1'b1;
              r_rem    <= '0;
              r_quo    <= {src, {W{1'b0}}};
              r_dsr    <= tgt;
              r_is_mod <= (opc == c_OP_MOD);
              r_cnt    <= '0;
            end else begin
              r_res  <= w_sc_res;
              r_ovf  <= w_sc_ovf;
              r_cc   <= w_sc_cc;
              r_done <= 1'b1;
            end
          end
        end
        S_DIVIDE: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          if (r_cnt == w_last) begin
            if (r_is_mod) begin
              r_res <= w_rem_nx[W-1:0];
            end else begin
              r_res <= w_quo_nx[2*W-1:W];
              r_ovf <= w_quo_nx[W-1:0];
            end
            r_cc    <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign res  = r_res;
  assign ovf  = r_ovf;
  assign cc   = r_cc;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire
